// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared widths, command/halt constants and loader state encoding
package program_loader_pkg;
  localparam int NB_DATA = 32;
  localparam int NB_BYTE = 8;
  localparam int N_ADDRESS = 64;
  localparam int NB_ADDR_IMEM = $clog2(N_ADDRESS);
  localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
  localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: UART byte input and instruction-memory write/status bundle
interface program_loader_if;
  import program_loader_pkg::*;
  logic [NB_BYTE-1:0] rx_data;
  logic rx_valid;
  logic imem_w_en;
  logic [NB_ADDR_IMEM-1:0] imem_w_addr;
  logic [NB_DATA-1:0] imem_w_data;
  logic pipe_hold;
  logic done;
  logic overflow;
  logic [NB_ADDR_IMEM:0] word_count;
  modport master (
    output rx_data, rx_valid,
    input imem_w_en, imem_w_addr, imem_w_data, pipe_hold, done, overflow, word_count
  );
  modport slave (
    input rx_data, rx_valid,
    output imem_w_en, imem_w_addr, imem_w_data, pipe_hold, done, overflow, word_count
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// program_loader_word_assembler: packs bytes big-endian into words, strobing on the 4th byte
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NB_BYTE-1:0] byte_i,
  output logic [NB_DATA-1:0] word_o,
  output logic               word_valid_o
);
  logic [1:0] cnt_q;
  logic [NB_DATA-NB_BYTE-1:0] sr_q;
  // the word is combinational so the top can register it on the 4th byte's edge
  assign word_o = {sr_q, byte_i};
  assign word_valid_o = en_i && cnt_q == 2'd3;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt_q <= '0;
      sr_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q <= word_o[NB_DATA-NB_BYTE-1:0];
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a UART byte stream into instruction memory and holds the pipeline until HALT
module program_loader
  import program_loader_pkg::*;
(
  input logic             clk_i,
  input logic             rst_i,
  program_loader_if.slave bus
);
  state_e state_q, state_d;
  logic [NB_DATA-1:0] word;
  logic word_valid, halt, last, cmd, restart, stay_done;
  logic [NB_ADDR_IMEM-1:0] idx_q, w_addr_q;
  logic [NB_DATA-1:0] w_data_q;
  logic [NB_ADDR_IMEM:0] count_q;
  logic w_en_q, done_q, hold_q, overflow_q;
  program_loader_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (state_q == LOAD && bus.rx_valid),
    .byte_i       (bus.rx_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );
  assign cmd = bus.rx_valid && bus.rx_data == CMD_LOAD;
  assign halt = word == HALT_WORD;
  assign last = idx_q == NB_ADDR_IMEM'(N_ADDRESS - 1);
  assign restart = state_q == DONE && cmd;
  assign stay_done = state_q == DONE && state_d == DONE;
  always_comb begin
    state_d = state_q;
    if (state_q != LOAD) state_d = cmd ? LOAD : state_q;
    else if (word_valid && (halt || last)) state_d = DONE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  // status flags trail the state by one edge so done/hold follow the HALT write cycle
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      w_en_q <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      idx_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      done_q <= 1'b0;
      hold_q <= 1'b1;
    end else begin
      w_en_q <= word_valid;
      done_q <= stay_done;
      hold_q <= !stay_done;
      if (word_valid) begin
        w_addr_q <= idx_q;
        w_data_q <= word;
        idx_q <= idx_q + 1'b1;
        count_q <= count_q + 1'b1;
        overflow_q <= last && !halt;
      end
      if (restart) begin
        idx_q <= '0;
        count_q <= '0;
        overflow_q <= 1'b0;
      end
    end
  assign bus.imem_w_en = w_en_q;
  assign bus.imem_w_addr = w_addr_q;
  assign bus.imem_w_data = w_data_q;
  assign bus.pipe_hold = hold_q;
  assign bus.done = done_q;
  assign bus.overflow = overflow_q;
  assign bus.word_count = count_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed byte streams with a write scoreboard and status checks
module tb_program_loader;
  import program_loader_pkg::*;
  typedef struct packed {
    logic [NB_ADDR_IMEM-1:0] addr;
    logic [NB_DATA-1:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wr_t exp_q[$];
  wr_t mon_e;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  program_loader_if bus();
  program_loader dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send(w[k*8+:8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int a, input logic [31:0] d);
    exp_q.push_back({NB_ADDR_IMEM'(a), d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic done, input logic hold,
                            input logic ovf, input int cnt);
    chk({tag, "_done"}, 64'(bus.done), 64'(done));
    chk({tag, "_hold"}, 64'(bus.pipe_hold), 64'(hold));
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'(ovf));
    chk({tag, "_count"}, 64'(bus.word_count), 64'(cnt));
  endtask

  // monitor: every write strobe must match the oldest expected write
  initial forever begin
    @(negedge clk);
    if (!rst && bus.imem_w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", bus.imem_w_addr, bus.imem_w_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 64'(bus.imem_w_addr), 64'(mon_e.addr));
        chk("write_data", 64'(bus.imem_w_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    do_reset();
    chk_status("reset", 1'b0, 1'b1, 1'b0, 0);
    chk("reset_wen", 64'(bus.imem_w_en), 64'd0);
    chk("reset_waddr", 64'(bus.imem_w_addr), 64'd0);
    chk("reset_wdata", 64'(bus.imem_w_data), 64'd0);
    // test 1: basic program with HALT
    push(0, 32'h2008_0005);
    push(1, 32'hFFFF_FFFF);
    send(8'h4C); idle(1);
    send(8'h20); send(8'h08); send(8'h00);
    chk("t1_no_early_write", 64'(bus.imem_w_en), 64'd0);
    send(8'h05);
    chk("t1_write_timing", 64'(bus.imem_w_en), 64'd1);
    idle(1);
    chk("t1_wen_one_cycle", 64'(bus.imem_w_en), 64'd0);
    chk("t1_data_held", 64'(bus.imem_w_data), 64'h2008_0005);
    send_word(32'hFFFF_FFFF);
    chk("t1_not_done_yet", 64'(bus.done), 64'd0);
    idle(2);
    chk_status("t1", 1'b1, 1'b0, 1'b0, 2);
    // test 2: junk in IDLE ignored
    do_reset();
    send(8'h00); send(8'h12); idle(2);
    chk_status("t2_idle", 1'b0, 1'b1, 1'b0, 0);
    push(0, 32'hAABB_CCDD);
    send(8'h4C);
    send_word(32'hAABB_CCDD);
    idle(2);
    chk_status("t2", 1'b0, 1'b1, 1'b0, 1);
    // test 3: fill memory without HALT
    do_reset();
    send(8'h4C);
    for (int i = 0; i < N_ADDRESS; i++) begin
      push(i, 32'h1000_0000 + i);
      send_word(32'h1000_0000 + i);
    end
    send_word(32'h5555_5555);
    idle(2);
    chk_status("t3", 1'b1, 1'b0, 1'b1, 64);
    chk("t3_last_addr", 64'(bus.imem_w_addr), 64'd63);
    // test 4: async reset mid-load
    do_reset();
    push(0, 32'h0102_0304);
    send(8'h4C);
    send_word(32'h0102_0304);
    send(8'h11); send(8'h22);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk_status("t4_async", 1'b0, 1'b1, 1'b0, 0);
    chk("t4_waddr", 64'(bus.imem_w_addr), 64'd0);
    chk("t4_wdata", 64'(bus.imem_w_data), 64'd0);
    @(negedge clk); rst = 1'b0;
    push(0, 32'hA1B2_C3D4);
    push(1, 32'hFFFF_FFFF);
    send(8'h4C);
    send_word(32'hA1B2_C3D4);
    send_word(32'hFFFF_FFFF);
    idle(2);
    chk_status("t4", 1'b1, 1'b0, 1'b0, 2);
    // test 5: back-to-back bytes across the write cycle
    do_reset();
    send(8'h4C); idle(1);
    push(0, 32'h0102_0304);
    push(1, 32'h0506_0708);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t5_write_with_byte5", 64'(bus.imem_w_en), 64'd1);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    idle(2);
    chk_status("t5", 1'b0, 1'b1, 1'b0, 2);
    // test 6: reload from DONE
    push(2, 32'hFFFF_FFFF);
    send_word(32'hFFFF_FFFF);
    idle(2);
    chk_status("t6_done", 1'b1, 1'b0, 1'b0, 3);
    send(8'h4C); idle(1);
    chk_status("t6_reload", 1'b0, 1'b1, 1'b0, 0);
    push(0, 32'hCAFE_BABE);
    send_word(32'hCAFE_BABE);
    idle(2);
    chk_status("t6", 1'b0, 1'b1, 1'b0, 1);
    idle(3);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
